// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the WB stage and the MDU.
// MDU results wait in a small FIFO. Pipeline writes win unless a drain is forced.
`timescale 1ns/1ps
module wb_port_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_load,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     mdu_valid,
  input  logic [4:0]               mdu_rd,
  input  logic [31:0]              mdu_data,
  output logic                     mdu_ready,
  output logic                     rf_load,
  output logic [4:0]               rf_rd,
  output logic [31:0]              rf_data,
  output logic                     pipe_stall,
  output logic [$clog2(DEPTH):0]   buf_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rptr;
  logic [AW-1:0] wptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;

  logic          pipe_req;
  logic          head_req;
  logic          hazard;
  logic          force_head;
  logic          head_win;
  logic          push;
  logic [AW-1:0] idx;

  assign pipe_req  = pipe_load & (pipe_rd != 5'd0);
  assign head_req  = (count != '0);
  assign mdu_ready = (count < CW'(DEPTH));
  assign buf_count = count;
  assign push      = mdu_valid & mdu_ready & (mdu_rd != 5'd0);

  // Any valid entry targeting the same rd must land before the pipeline write.
  always_comb begin
    hazard = 1'b0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + AW'(i);
      if ((CW'(i) < count) && (rd_mem[idx] == pipe_rd)) hazard = 1'b1;
    end
  end

  assign force_head = head_req & ((count == CW'(DEPTH)) |
                                  (starve == SW'(STARVE_MAX)) |
                                  (pipe_req & hazard));
  assign head_win   = head_req & (force_head | ~pipe_req);

  // Outputs are held quiet while reset is asserted, whatever the WB inputs do.
  always_comb begin
    rf_load    = 1'b0;
    rf_rd      = 5'd0;
    rf_data    = 32'd0;
    pipe_stall = 1'b0;
    if (!rst) begin
      if (head_win) begin
        rf_load    = 1'b1;
        rf_rd      = rd_mem[rptr];
        rf_data    = data_mem[rptr];
        pipe_stall = pipe_req;
      end else if (pipe_req) begin
        rf_load = 1'b1;
        rf_rd   = pipe_rd;
        rf_data = pipe_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      starve <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_mem[i]   <= 5'd0;
        data_mem[i] <= 32'd0;
      end
    end else begin
      if (push) begin
        rd_mem[wptr]   <= mdu_rd;
        data_mem[wptr] <= mdu_data;
        wptr           <= wptr + AW'(1);
      end
      if (head_win) rptr <= rptr + AW'(1);

      case ({push, head_win})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (head_win || !head_req) starve <= '0;
      else if (starve != SW'(STARVE_MAX)) starve <= starve + SW'(1);
    end
  end

endmodule
